// File: rtl/ext_pipe.sv
// Immediate extension unit with a small FIFO output buffer and a saturating illegal-op counter.
// Optional byte extension modes (ops 100/101) are enabled by defining EXT_PIPE_BYTE_MODES_EN.
module ext_pipe #(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IMM_W-1:0]           in_imm,
    input  logic [2:0]                 in_op,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       out_err,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [7:0]                 err_cnt
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    // Returns {err, result}; illegal ops yield a zero result with err set.
    function automatic logic [OUT_W:0] ext_fn(input logic [IMM_W-1:0] imm, input logic [2:0] op);
        logic signed [OUT_W-1:0] sext;
        logic        [OUT_W-1:0] res;
        logic                    err;
        sext = {{(OUT_W-IMM_W){imm[IMM_W-1]}}, imm};
        res  = '0;
        err  = 1'b0;
        case (op)
            3'b000:  res = {{(OUT_W-IMM_W){1'b0}}, imm};
            3'b001:  res = sext;
            3'b010:  res = {imm, {(OUT_W-IMM_W){1'b0}}};
            3'b011:  res = sext <<< 2;
`ifdef EXT_PIPE_BYTE_MODES_EN
            3'b100:  res = {{(OUT_W-8){imm[7]}}, imm[7:0]};
            3'b101:  res = {{(OUT_W-8){1'b0}}, imm[7:0]};
`endif
            default: err = 1'b1;
        endcase
        return {err, res};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    logic [OUT_W:0]     ext_p0;
    logic               accept;
    logic               pop;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OUT_W-1:0]   data_mem [DEPTH];
    logic [TAG_W-1:0]   tag_mem  [DEPTH];
    logic               err_mem  [DEPTH];

    assign in_ready  = (count < FULL) && !reset;
    assign out_valid = (count != '0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign ext_p0    = ext_fn(in_imm, in_op);

    // Outputs are forced to zero while the buffer is empty so reset leaves them clean.
    assign out_data = out_valid ? data_mem[rd_ptr] : '0;
    assign out_tag  = out_valid ? tag_mem[rd_ptr]  : '0;
    assign out_err  = out_valid ? err_mem[rd_ptr]  : 1'b0;

    // stage p0 -> buffer
    always_ff @(posedge clk) begin
        if (accept) begin
            data_mem[wr_ptr] <= ext_p0[OUT_W-1:0];
            tag_mem[wr_ptr]  <= in_tag;
            err_mem[wr_ptr]  <= ext_p0[OUT_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_cnt <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (ext_p0[OUT_W]) begin
                    err_cnt <= sat_inc(err_cnt);
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/ext_pipe.md
EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 Parameter IMM_W, default 16, immediate field width; legal range 8..OUT_W-2.
REQ-002 Parameter OUT_W, default 32, extended result width; OUT_W >= IMM_W+2.
REQ-003 Parameter DEPTH, default 2, output buffer entries; power of two, >= 2.
REQ-004 Parameter TAG_W, default 5, sideband tag width (e.g. destination register).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  request present.
REQ-008 in_ready  output  1  block can accept a request this cycle.
REQ-009 in_imm  input  IMM_W  immediate to extend.
REQ-010 in_op  input  3  extension mode.
REQ-011 in_tag  input  TAG_W  sideband, carried unchanged.
REQ-012 out_valid  output  1  head entry valid.
REQ-013 out_ready  input  1  consumer accepts head entry.
REQ-014 out_data  output  OUT_W  extended result.
REQ-015 out_tag  output  TAG_W  tag of head entry.
REQ-016 out_err  output  1  head entry came from an illegal in_op.
REQ-017 count  output  $clog2(DEPTH+1)  entries currently buffered.
REQ-018 err_cnt  output  8  saturating count of illegal requests accepted.

Function
REQ-019 Accept = in_valid && in_ready; pop = out_valid && out_ready.
REQ-020 in_ready = (count < DEPTH) && !reset; depends only on registered state, not on out_ready.
REQ-021 Latency: accepted request visible on out_* no earlier than the next cycle; one accept per cycle max.
REQ-022 Buffer is FIFO ordered; out_data/out_tag/out_err hold stable while out_valid && !out_ready.
REQ-023 Simultaneous accept and pop: count unchanged, ordering preserved; pop from full frees space next cycle only.
REQ-024 out_valid = (count != 0); pop when empty is impossible by construction.
REQ-025 op 000: zero-extend in_imm to OUT_W.
REQ-026 op 001: sign-extend in_imm (bit IMM_W-1) to OUT_W.
REQ-027 op 010: upper placement, {in_imm, (OUT_W-IMM_W) zeros}.
REQ-028 op 011: sign-extend then shift left by 2, result truncated to OUT_W (branch offset).
REQ-029 Illegal op: entry stored with out_data = 0, out_err = 1; err_cnt increments on accept, saturates at 255.
REQ-030 Legal op: out_err = 0; err_cnt unchanged.
REQ-031 Request with in_valid low or in_ready low is ignored; in_imm/in_op don't-care.

Reset
REQ-032 On reset: count = 0, out_valid = 0, out_data = 0, out_tag = 0, out_err = 0, err_cnt = 0, in_ready = 0.
REQ-033 Reset mid-operation discards all buffered entries; in_ready = 1 the first cycle after reset deasserts.
REQ-034 Accept or pop in a reset cycle has no effect.

Configuration
REQ-035 Macro EXT_PIPE_BYTE_MODES_EN: when defined, op 100 sign-extends in_imm[7:0] and op 101 zero-extends in_imm[7:0]; ops 110, 111 illegal.
REQ-036 Without EXT_PIPE_BYTE_MODES_EN: ops 100-111 all illegal per REQ-029.

Verification
REQ-037 Defaults, out_ready=1, op=001 imm=16'h8001 tag=3 -> next cycle out_valid=1, out_data=32'hFFFF8001, out_tag=3, out_err=0.
REQ-038 op=010 imm=16'h1234 -> 32'h12340000; op=011 imm=16'hFFFF -> 32'hFFFFFFFC; op=000 imm=16'h8000 -> 32'h00008000.
REQ-039 out_ready=0, push 3 requests back-to-back -> 2 accepted, in_ready=0 third cycle, count=2; release out_ready -> entries drain in order, data stable while stalled.
REQ-040 op=110 x300 accepted -> each out_err=1, out_data=0, err_cnt=255 (saturated); with macro, op=100 imm=16'h0080 -> 32'hFFFFFF80, err_cnt unchanged.
REQ-041 Buffer holding 2 entries, assert reset one cycle -> count=0, out_valid=0, err_cnt=0, in_ready=0 during reset, 1 next cycle.
